// File: rtl/cache_mem_responder_pkg.sv
// cache_mem_responder_pkg
// Shared line geometry and responder state codes for the write-back cache
// and its memory-side responder. Both ends import this package so that they
// agree on line width, address width and where the line index begins.
//   BLOCKSIZE    line width in bits (four 32-bit words)
//   ADDRSIZE     byte address width
//   OFFSETBITS   byte-in-line offset bits; the line index starts above them
//   WORDSEL_*    position of the word-select field inside the line offset
//   CNT_BITS     width of the latency counter (latency 1..255)
//   resp_state_t responder FSM states
package cache_mem_responder_pkg;

    localparam int BLOCKSIZE    = 128;
    localparam int ADDRSIZE     = 32;
    localparam int OFFSETBITS   = 4;
    localparam int WORDSIZE     = 32;
    localparam int WORDSEL_LSB  = 2;
    localparam int WORDSEL_BITS = 2;
    localparam int CNT_BITS     = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_BUSY = 2'b01,
        ST_RESP = 2'b10
    } resp_state_t;

    // Selects which 32-bit word of a line a byte address falls in.
    function automatic logic [WORDSEL_BITS-1:0] word_sel(input logic [ADDRSIZE-1:0] addr);
        return addr[WORDSEL_LSB +: WORDSEL_BITS];
    endfunction

endpackage

// File: rtl/cache_mem_responder_mem_line_array.sv
// mem_line_array
// Line storage for the memory responder: 2**DEPTH_LOG2 lines of BLOCKSIZE
// bits, one synchronous write port and one synchronous read port whose
// output register is the responder's read-data output.
//   clk       rising-edge clock
//   rst       asynchronous active-low reset; clears every line and rd_data
//   wr_en     write wr_data into line wr_index at the edge
//   wr_index  line to write
//   wr_data   line contents to write
//   rd_en     load line rd_index into rd_data at the edge
//   rd_index  line to read
//   rd_data   registered read line, held until the next rd_en
module mem_line_array
    import cache_mem_responder_pkg::*;
#(
    parameter int DEPTH_LOG2 = 12
)
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_en,
    input  logic [DEPTH_LOG2-1:0] wr_index,
    input  logic [BLOCKSIZE-1:0]  wr_data,
    input  logic                  rd_en,
    input  logic [DEPTH_LOG2-1:0] rd_index,
    output logic [BLOCKSIZE-1:0]  rd_data
);

    localparam int DEPTH = 1 << DEPTH_LOG2;

    logic [BLOCKSIZE-1:0] lines [DEPTH];

    // The whole array is cleared on reset so a freshly reset memory reads as
    // zero everywhere; rd_data only changes on a read commit.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                lines[i] <= '0;
            end
            rd_data <= '0;
        end else begin
            if (wr_en) begin
                lines[wr_index] <= wr_data;
            end
            if (rd_en) begin
                rd_data <= lines[rd_index];
            end
        end
    end

endmodule

// File: rtl/cache_mem_responder.sv
// cache_mem_responder
// Memory-side responder for the direct-mapped write-back cache. Accepts a
// single-cycle read (allocate) or write (writeback) request, waits LATENCY
// cycles, commits or returns one full line, then pulses mem_req_done.
//   clk           rising-edge clock
//   rst           asynchronous active-low reset
//   mem_req_vld   request pulse, sampled every cycle
//   mem_req_wen   1 = line write, 0 = line read
//   mem_addr      byte address; only the line-index bits are used
//   mem_wr_data   write line, sampled with the request
//   mem_rd_data   read line, held until the next read commits
//   mem_req_done  one-cycle completion pulse
//   mem_busy      a request is outstanding
//   mem_err       sticky: a request arrived while busy and was dropped
module cache_mem_responder
    import cache_mem_responder_pkg::*;
#(
    parameter int DEPTH_LOG2 = 12,
    parameter int LATENCY    = 4
)
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 mem_req_vld,
    input  logic                 mem_req_wen,
    input  logic [ADDRSIZE-1:0]  mem_addr,
    input  logic [BLOCKSIZE-1:0] mem_wr_data,
    output logic [BLOCKSIZE-1:0] mem_rd_data,
    output logic                 mem_req_done,
    output logic                 mem_busy,
    output logic                 mem_err
);

    resp_state_t           state;
    logic [CNT_BITS-1:0]   counter;
    logic                  wen_q;
    logic [DEPTH_LOG2-1:0] index_q;
    logic [BLOCKSIZE-1:0]  wdata_q;

    logic [DEPTH_LOG2-1:0] req_index;
    logic                  accept;
    logic                  go_resp;
    logic                  commit_wen;
    logic [DEPTH_LOG2-1:0] commit_index;
    logic [BLOCKSIZE-1:0]  commit_wdata;
    logic                  unused_addr;

    // Address bits above the index are ignored, so higher addresses alias.
    assign req_index   = mem_addr[OFFSETBITS +: DEPTH_LOG2];
    assign unused_addr = ^{mem_addr[ADDRSIZE-1:OFFSETBITS+DEPTH_LOG2],
                           mem_addr[OFFSETBITS-1:0]};

    // With LATENCY=1 the commit happens on the same edge that accepts the
    // request, before anything is latched, so the commit port takes the
    // live request fields in that case and the latched copies otherwise.
    always_comb begin
        accept       = 1'b0;
        go_resp      = 1'b0;
        commit_wen   = wen_q;
        commit_index = index_q;
        commit_wdata = wdata_q;
        accept  = mem_req_vld && (state == ST_IDLE || state == ST_RESP);
        go_resp = (accept && LATENCY == 1) ||
                  (state == ST_BUSY && counter == CNT_BITS'(1));
        if (accept) begin
            commit_wen   = mem_req_wen;
            commit_index = req_index;
            commit_wdata = mem_wr_data;
        end
    end

    // Request FSM. Outputs are registered from the next state so that
    // mem_req_done is high exactly during RESP and mem_busy outside IDLE.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= ST_IDLE;
            counter      <= '0;
            wen_q        <= 1'b0;
            index_q      <= '0;
            wdata_q      <= '0;
            mem_req_done <= 1'b0;
            mem_busy     <= 1'b0;
            mem_err      <= 1'b0;
        end else begin
            mem_req_done <= go_resp;
            case (state)
                ST_IDLE, ST_RESP: begin
                    if (mem_req_vld) begin
                        wen_q    <= mem_req_wen;
                        index_q  <= req_index;
                        wdata_q  <= mem_wr_data;
                        counter  <= CNT_BITS'(LATENCY - 1);
                        state    <= (LATENCY == 1) ? ST_RESP : ST_BUSY;
                        mem_busy <= 1'b1;
                    end else begin
                        state    <= ST_IDLE;
                        mem_busy <= 1'b0;
                    end
                end
                ST_BUSY: begin
                    if (mem_req_vld) begin
                        mem_err <= 1'b1;
                    end
                    if (counter == CNT_BITS'(1)) begin
                        state <= ST_RESP;
                    end
                    counter  <= counter - CNT_BITS'(1);
                    mem_busy <= 1'b1;
                end
                default: begin
                    state    <= ST_IDLE;
                    mem_busy <= 1'b0;
                end
            endcase
        end
    end

    mem_line_array #(
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_array (
        .clk      (clk),
        .rst      (rst),
        .wr_en    (go_resp && commit_wen),
        .wr_index (commit_index),
        .wr_data  (commit_wdata),
        .rd_en    (go_resp && !commit_wen),
        .rd_index (commit_index),
        .rd_data  (mem_rd_data)
    );

endmodule

// File: tb/tb_cache_mem_responder.sv
// tb_cache_mem_responder
// Drives two responders (LATENCY=4 and LATENCY=1) and scores every
// completion against a queue of expectations pushed when each request is
// issued; a small line model supplies expected read data.
module tb_cache_mem_responder;

    logic         clk;
    logic         rst;

    logic         vld4, wen4, done4, busy4, err4;
    logic [31:0]  addr4;
    logic [127:0] wdata4, rd4;

    logic         vld1, wen1, done1, busy1, err1;
    logic [31:0]  addr1;
    logic [127:0] wdata1, rd1;

    typedef struct {
        int           cyc;
        logic         is_rd;
        int           key;
        logic [127:0] data;
        logic [127:0] wdata;
    } exp_t;

    exp_t         q4[$];
    exp_t         q1[$];
    logic [127:0] model [int];
    logic [127:0] last_rd [2];

    int cyc          = 0;
    int tests_run    = 0;
    int tests_failed = 0;

    localparam logic [127:0] D1 = 128'hDEAD_0000_1111_2222_3333_4444_5555_BEEF;
    localparam logic [127:0] D2 = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
    localparam logic [127:0] D3 = 128'hA5A5_A5A5_5A5A_5A5A_C3C3_C3C3_3C3C_3C3C;
    localparam logic [127:0] D4 = 128'hFFFF_0000_FFFF_0000_1234_5678_9ABC_DEF0;
    localparam logic [127:0] D5 = 128'hBAD0_BAD0_BAD0_BAD0_BAD0_BAD0_BAD0_BAD0;
    localparam logic [127:0] D6 = 128'h6666_6666_0000_0001_6666_6666_0000_0002;
    localparam logic [127:0] D7 = 128'h7777_7777_0000_0003_7777_7777_0000_0004;

    cache_mem_responder #(.DEPTH_LOG2(12), .LATENCY(4)) dut4 (
        .clk          (clk),
        .rst          (rst),
        .mem_req_vld  (vld4),
        .mem_req_wen  (wen4),
        .mem_addr     (addr4),
        .mem_wr_data  (wdata4),
        .mem_rd_data  (rd4),
        .mem_req_done (done4),
        .mem_busy     (busy4),
        .mem_err      (err4)
    );

    cache_mem_responder #(.DEPTH_LOG2(12), .LATENCY(1)) dut1 (
        .clk          (clk),
        .rst          (rst),
        .mem_req_vld  (vld1),
        .mem_req_wen  (wen1),
        .mem_addr     (addr1),
        .mem_wr_data  (wdata1),
        .mem_rd_data  (rd1),
        .mem_req_done (done1),
        .mem_busy     (busy1),
        .mem_err      (err1)
    );

    // Free-running clock and a cycle counter that advances on each edge.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string tag, input logic [127:0] got, input logic [127:0] expv);
        tests_run++;
        if (got !== expv) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %h expected %h (cycle %0d)", tag, got, expv, cyc);
        end
    endtask

    function automatic logic [127:0] model_rd(input int key);
        return model.exists(key) ? model[key] : 128'h0;
    endfunction

    // Raises a request on the chosen responder one tick after the next edge
    // and records what its completion must look like. vld stays high until
    // releaseRequest, so consecutive calls form a back-to-back burst.
    task automatic applyStimulus(input int which, input logic wen, input logic [31:0] addr,
                                 input logic [127:0] wdata);
        exp_t e;
        @(posedge clk);
        #1;
        e.key   = which * 4096 + int'(addr[15:4]);
        e.cyc   = cyc + ((which == 0) ? 4 : 1);
        e.is_rd = !wen;
        e.wdata = wdata;
        e.data  = wen ? last_rd[which] : model_rd(e.key);
        if (which == 0) begin
            vld4 = 1'b1; wen4 = wen; addr4 = addr; wdata4 = wdata;
            q4.push_back(e);
        end else begin
            vld1 = 1'b1; wen1 = wen; addr1 = addr; wdata1 = wdata;
            q1.push_back(e);
        end
    endtask

    // Drops vld and scrambles the request fields so that anything the
    // responder failed to latch shows up as wrong data.
    task automatic releaseRequest(input int which);
        @(posedge clk);
        #1;
        if (which == 0) begin
            vld4 = 1'b0; wen4 = $urandom_range(0, 1) == 1; addr4 = $urandom;
            wdata4 = {$urandom, $urandom, $urandom, $urandom};
        end else begin
            vld1 = 1'b0; wen1 = $urandom_range(0, 1) == 1; addr1 = $urandom;
            wdata1 = {$urandom, $urandom, $urandom, $urandom};
        end
    endtask

    // Returns late in the cycle in which the last expected completion was
    // seen, so the next applyStimulus drives in the following cycle.
    task automatic waitIdle(input int which, input int bound);
        bit empty;
        empty = 1'b0;
        for (int i = 0; i < bound && !empty; i++) begin
            @(negedge clk);
            #2;
            empty = (which == 0) ? (q4.size() == 0) : (q1.size() == 0);
        end
        if (!empty) checkOutput("wait_timeout", 1'b0, 1'b1);
    endtask

    task automatic doReset();
        @(posedge clk);
        #1;
        rst = 1'b0;
        q4.delete();
        q1.delete();
        model.delete();
        last_rd[0] = '0;
        last_rd[1] = '0;
        @(negedge clk);
        checkOutput("rst_done4", done4, 1'b0);
        checkOutput("rst_busy4", busy4, 1'b0);
        checkOutput("rst_err4",  err4,  1'b0);
        checkOutput("rst_rd4",   rd4,   128'h0);
        checkOutput("rst_err1",  err1,  1'b0);
        @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    // Scores one responder for the current cycle: done must be high exactly
    // when an expectation falls due and low otherwise.
    task automatic scoreboard(input int which, input logic done, input logic [127:0] rd);
        exp_t e;
        bit   have;
        have = 1'b0;
        if (which == 0) begin
            if (q4.size() > 0 && q4[0].cyc <= cyc) begin e = q4.pop_front(); have = 1'b1; end
        end else begin
            if (q1.size() > 0 && q1[0].cyc <= cyc) begin e = q1.pop_front(); have = 1'b1; end
        end
        if (have) begin
            checkOutput((which == 0) ? "done_lat4" : "done_lat1", done, 1'b1);
            if (e.is_rd) begin
                if (done) checkOutput((which == 0) ? "rd_data4" : "rd_data1", rd, e.data);
                last_rd[which] = e.data;
            end else begin
                if (done) checkOutput((which == 0) ? "rd_hold4" : "rd_hold1", rd, e.data);
                model[e.key] = e.wdata;
            end
        end else if (done) begin
            checkOutput((which == 0) ? "spurious_done4" : "spurious_done1", done, 1'b0);
        end
    endtask

    always @(negedge clk) begin
        if (rst) begin
            scoreboard(0, done4, rd4);
            scoreboard(1, done1, rd1);
        end
    end

    initial begin
        rst  = 1'b0;
        vld4 = 1'b0; wen4 = 1'b0; addr4 = '0; wdata4 = '0;
        vld1 = 1'b0; wen1 = 1'b0; addr1 = '0; wdata1 = '0;
        last_rd[0] = '0;
        last_rd[1] = '0;
        repeat (2) @(posedge clk);
        doReset();

        // Read of a freshly reset line, then write/read of the same line.
        applyStimulus(0, 1'b0, 32'h0000_1230, '0);  releaseRequest(0); waitIdle(0, 20);
        applyStimulus(0, 1'b1, 32'h0000_1230, D1);  releaseRequest(0); waitIdle(0, 20);
        applyStimulus(0, 1'b0, 32'h0000_1230, '0);  releaseRequest(0); waitIdle(0, 20);

        // Writeback then allocate in the very next cycle, plus aliasing.
        applyStimulus(0, 1'b1, 32'h0000_4010, D2);  releaseRequest(0); waitIdle(0, 20);
        applyStimulus(0, 1'b0, 32'h0000_8010, '0);  releaseRequest(0); waitIdle(0, 20);
        checkOutput("err_after_wb_alloc", err4, 1'b0);
        applyStimulus(0, 1'b1, 32'h0000_0010, D3);  releaseRequest(0); waitIdle(0, 20);
        applyStimulus(0, 1'b0, 32'h0001_0010, '0);  releaseRequest(0); waitIdle(0, 20);
        applyStimulus(0, 1'b1, 32'h0000_FFF0, D4);  releaseRequest(0); waitIdle(0, 20);
        applyStimulus(0, 1'b0, 32'h0001_0000, '0);  releaseRequest(0); waitIdle(0, 20);
        applyStimulus(0, 1'b0, 32'hABCD_FFF0, '0);  releaseRequest(0); waitIdle(0, 20);
        applyStimulus(0, 1'b0, 32'h0000_4010, '0);  releaseRequest(0); waitIdle(0, 20);

        // A request while busy is dropped and flagged; timing is unaffected.
        applyStimulus(0, 1'b0, 32'h0000_1230, '0);
        releaseRequest(0);
        @(negedge clk);
        checkOutput("busy_mid", busy4, 1'b1);
        @(posedge clk);
        #1;
        vld4 = 1'b1; wen4 = 1'b1; addr4 = 32'h0000_1230; wdata4 = D5;
        releaseRequest(0);
        waitIdle(0, 20);
        checkOutput("err_set", err4, 1'b1);
        @(negedge clk);
        checkOutput("busy_idle", busy4, 1'b0);
        applyStimulus(0, 1'b0, 32'h0000_1230, '0);  releaseRequest(0); waitIdle(0, 20);
        checkOutput("err_sticky", err4, 1'b1);

        // Reset two cycles into a write abandons it.
        applyStimulus(0, 1'b1, 32'h0000_1230, D5);
        releaseRequest(0);
        doReset();
        repeat (6) @(posedge clk);
        applyStimulus(0, 1'b0, 32'h0000_1230, '0);  releaseRequest(0); waitIdle(0, 20);

        // LATENCY=1: requests from IDLE every second cycle, then from RESP.
        applyStimulus(1, 1'b1, 32'h0000_0020, D6);  releaseRequest(1); waitIdle(1, 10);
        applyStimulus(1, 1'b1, 32'h0000_0030, D7);  releaseRequest(1); waitIdle(1, 10);
        applyStimulus(1, 1'b0, 32'h0000_0020, '0);  releaseRequest(1);
        applyStimulus(1, 1'b0, 32'h0000_0030, '0);  releaseRequest(1);
        waitIdle(1, 10);
        applyStimulus(1, 1'b0, 32'h0000_0030, '0);
        applyStimulus(1, 1'b0, 32'h0000_0020, '0);
        applyStimulus(1, 1'b0, 32'h0000_0030, '0);
        releaseRequest(1);
        waitIdle(1, 10);
        checkOutput("err1_clear", err1, 1'b0);

        repeat (5) @(posedge clk);
        checkOutput("sb_empty", 128'(q4.size() + q1.size()), 128'h0);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
